ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch stage: owns the program counter, issues one read per cycle to a synchronous instruction memory, and buffers the returned words in a 2-entry skid FIFO. The FIFO absorbs the decode stage's combinational stall without losing in-flight reads. Sits directly upstream of the decode stage and feeds its `v_i` / `inst_i` / `origaddr_i` / `stall_o` handshake. Branch redirects from execute flush the FIFO and restart fetch at the target.

## Interface
- `RESET_PC`, default 0, first fetch address after reset; `ADDR` bits wide.
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `imem_re_o`  out  1  read request this cycle
- `imem_addr_o`  out  `ADDR`  read address; word-addressed
- `imem_data_i`  in  `WORD`  read data, valid the cycle after the request
- `v_o`  out  1  `inst_o` / `origaddr_o` valid; connects to decode `v_i`
- `inst_o`  out  `WORD`  instruction
- `origaddr_o`  out  `ADDR`  address of `inst_o`
- `stall_i`  in  1  decode cannot accept; connects to decode `stall_o`; may be combinational
- `br_i`  in  1  redirect request from execute
- `br_addr_i`  in  `ADDR`  redirect target

## Operation
- **State:**
  - `pc_r`: next sequential fetch address.
  - `inflight_r`: a read was issued last cycle.
  - `inflight_addr_r`: the address of that read.
  - FIFO: 2 entries of {inst, addr} plus `count` (0..2).
- **Pop:** `pop = v_o & ~stall_i`. `v_o = (count != 0)`. `inst_o` / `origaddr_o` are the FIFO head registers, with no combinational path from `imem_data_i`.
- **Push:** `push = inflight_r & ~br_i`. Pushes {`imem_data_i`, `inflight_addr_r`}.
- **Issue:**
  - `issue = br_i | (count + inflight_r - pop < 2)`.
  - `imem_re_o = issue`.
  - `imem_addr_o = br_i ? br_addr_i : pc_r`.
  - On issue: `pc_r <= imem_addr_o + 1`, `inflight_r <= 1`, `inflight_addr_r <= imem_addr_o`. Otherwise `inflight_r <= 0` and `pc_r` holds.
- **Credit rule:** `count + inflight_r` never exceeds 2, so a returning read always has a slot. Overflow is a design error; assert it.
- **Redirect (`br_i = 1`):**
  - Has priority over `stall_i` and every other event.
  - `count <= 0`.
  - Data returning this cycle is dropped.
  - The target read is issued in the same cycle.
- **FIFO behaviour:**
  - Simultaneous push and pop at `count == 2`: legal; count stays 2.
  - Push at `count == 0`: the entry becomes head next cycle.
- **PC arithmetic:** modulo 2^`ADDR`; `2^ADDR - 1` wraps to 0.
- Downstream squash of younger instructions already in decode is owned by execute, not by this block.

## Timing
- **Reset values:**
  - `v_o = 0`, `inst_o = 0`, `origaddr_o = 0`.
  - `count = 0`, `inflight_r = 0`, `pc_r = RESET_PC`.
  - `imem_re_o = 1`, `imem_addr_o = RESET_PC`; these are combinational from reset state.
  - Reset mid-operation clears all state immediately (asynchronous).
- **Latency:**
  - Issue at cycle t → push at the end of t+1 → `v_o` at t+2.
  - First instruction appears 2 cycles after reset release.
  - Redirect penalty: target valid at t+2 after the `br_i` cycle.
- **Steady state:** 1 instruction per cycle while `stall_i = 0`; no bubbles.
- **Stall:**
  - Stall held: FIFO fills to 2 and `imem_re_o` drops.
  - On release: head pops the same cycle, issue resumes the same cycle, and throughput returns to 1/cycle with no gap.
- Outputs hold stable while `v_o & stall_i`.

## Structure
- `WORD` and `ADDR` come from the shared `include/params.vh`.
- Add `W_FETCH_CNT` (=2) there.
- Sub-module `fetch_fifo`: 2-entry register FIFO.
  - Inputs: push, pop, flush, data.
  - Outputs: head, count.
  - Flush has priority over push.
- PC, issue logic and in-flight tracking stay in `ifetch`.

## Test plan
- **Basic flow:** `RESET_PC = 0`, mem[i] = 0x100 + i, `stall_i = 0`.
  - `v_o` rises at cycle 2 after reset release.
  - `inst_o` = 0x100, 0x101, 0x102… with `origaddr_o` 0, 1, 2…, one per cycle.
- **Stall:** `stall_i` high for 3 cycles mid-stream.
  - `count` saturates at 2 and `imem_re_o` goes to 0.
  - On release the sequence resumes with no word lost or duplicated and no bubble.
- **Redirect:** `br_i` with `br_addr_i = 0x40` while `origaddr_o = 5`.
  - Addresses 6/7 are never presented after the redirect cycle.
  - `v_o` with `origaddr_o = 0x40` appears 2 cycles later, followed by 0x41.
- **Redirect during full stall:** `br_i` while `stall_i = 1` and `count = 2`.
  - FIFO is flushed and the target read issues the same cycle.
  - After the stall clears, the first output is the target.
- **Wrap:** `RESET_PC = 2^ADDR - 2`.
  - `origaddr_o` sequence is `2^ADDR - 2`, `2^ADDR - 1`, 0, 1.
- **Asynchronous reset:** `rst` asserted mid-stream, between clock edges.
  - `v_o`, `inst_o` and `origaddr_o` go to 0 immediately.
  - After release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared widths and types for the instruction fetch stage.
package ifetch_pkg;

  localparam int WORD        = 32;  // instruction width
  localparam int ADDR        = 8;   // word-address width
  localparam int W_FETCH_CNT = 2;   // width of the FIFO occupancy count (0..2)

  typedef logic [WORD-1:0]        word_t;
  typedef logic [ADDR-1:0]        addr_t;
  typedef logic [W_FETCH_CNT-1:0] cnt_t;

  // One buffered fetch result: the instruction and the address it came from.
  typedef struct packed {
    word_t inst;
    addr_t addr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fetch_fifo.sv
// Two-entry register FIFO holding fetched {inst, addr} pairs.
// The head register drives the stage outputs directly, so there is no
// combinational path from the write data to the head.
module fetch_fifo
  import ifetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t data,
  output fetch_entry_t head,
  output cnt_t         count
);

  fetch_entry_t head_r;
  fetch_entry_t tail_r;
  cnt_t         count_r;

  // Storage and occupancy; flush wins over push and pop.
  // NOTE: the two entries are reset along with the count because the head
  // is a visible output that must read as zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (flush) begin
      count_r <= '0;
    end else begin
      // NOTE: non-blocking assignments let head_r <= tail_r and
      // tail_r <= data happen in the same edge without ordering hazards.
      unique case ({push, pop})
        2'b10: begin
          if (count_r == 2'd0) head_r <= data;
          else                 tail_r <= data;
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          head_r  <= tail_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd2) begin
            head_r <= tail_r;
            tail_r <= data;
          end else begin
            head_r <= data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = head_r;
  assign count = count_r;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: PC, one-read-per-cycle issue to a synchronous
// instruction memory, in-flight tracking and a 2-entry skid FIFO toward
// decode. A branch redirect flushes everything and fetches the target.
module ifetch
  import ifetch_pkg::*;
#(
  parameter addr_t RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_re_o,
  output logic [ADDR-1:0] imem_addr_o,
  input  logic [WORD-1:0] imem_data_i,
  output logic            v_o,
  output logic [WORD-1:0] inst_o,
  output logic [ADDR-1:0] origaddr_o,
  input  logic            stall_i,
  input  logic            br_i,
  input  logic [ADDR-1:0] br_addr_i
);

  addr_t        pc_r;
  logic         inflight_r;
  addr_t        inflight_addr_r;

  cnt_t         count;
  fetch_entry_t head;
  logic         pop;
  logic         push;
  logic         issue;
  logic [W_FETCH_CNT:0] credit;

  // Handshake and issue decisions; outstanding slots after this cycle's pop
  // must leave room for the read being issued.
  // NOTE: every signal gets a default first so no path through the block
  // leaves a value held, which would infer a latch.
  always_comb begin
    pop         = 1'b0;
    push        = 1'b0;
    credit      = '0;
    issue       = 1'b0;
    imem_addr_o = pc_r;
    pop    = v_o & ~stall_i;
    push   = inflight_r & ~br_i;
    credit = {1'b0, count} + {{W_FETCH_CNT{1'b0}}, inflight_r}
           - {{W_FETCH_CNT{1'b0}}, pop};
    issue  = br_i | (credit < 3'd2);
    if (br_i) imem_addr_o = br_addr_i;
  end

  assign imem_re_o = issue;

  // PC and in-flight read tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r            <= RESET_PC;
      inflight_r      <= 1'b0;
      inflight_addr_r <= '0;
    end else begin
      inflight_r <= issue;
      if (issue) begin
        pc_r            <= imem_addr_o + addr_t'(1);
        inflight_addr_r <= imem_addr_o;
      end
    end
  end

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (br_i),
    .data  ('{inst: imem_data_i, addr: inflight_addr_r}),
    .head  (head),
    .count (count)
  );

  assign v_o        = (count != '0);
  assign inst_o     = head.inst;
  assign origaddr_o = head.addr;

  // A returning read must always find a free slot.
  a_credit : assert property (@(posedge clk) disable iff (!rst)
    ({1'b0, count} + {{W_FETCH_CNT{1'b0}}, inflight_r}) <= 3'd2);

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: a directed cycle table, a wrap-around
// instance, an asynchronous reset mid-stream and a randomized run against
// a stream-level reference model.
module tb_ifetch;
  import ifetch_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            stall = 1'b0;
  logic            br = 1'b0;
  logic [ADDR-1:0] br_addr = '0;

  logic            imem_re, w_imem_re;
  logic [ADDR-1:0] imem_addr, w_imem_addr;
  logic [WORD-1:0] imem_data = '0, w_imem_data = '0;
  logic            v, w_v;
  logic [WORD-1:0] inst, w_inst;
  logic [ADDR-1:0] origaddr, w_origaddr;

  int errors = 0;
  int checks = 0;

  // Stream-level reference: consecutive addresses from the last restart
  // point; output valid from the second cycle after any restart.
  int              cyc = 0;
  int              last_evt = 0;
  logic [ADDR-1:0] next_addr = '0;

  always #5 clk = ~clk;

  ifetch u_dut (
    .clk(clk), .rst(rst),
    .imem_re_o(imem_re), .imem_addr_o(imem_addr), .imem_data_i(imem_data),
    .v_o(v), .inst_o(inst), .origaddr_o(origaddr),
    .stall_i(stall), .br_i(br), .br_addr_i(br_addr)
  );

  ifetch #(.RESET_PC(8'hFE)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_re_o(w_imem_re), .imem_addr_o(w_imem_addr), .imem_data_i(w_imem_data),
    .v_o(w_v), .inst_o(w_inst), .origaddr_o(w_origaddr),
    .stall_i(1'b0), .br_i(1'b0), .br_addr_i(8'h00)
  );

  function automatic logic [WORD-1:0] mem_word(input logic [ADDR-1:0] a);
    return 32'h100 + {24'h0, a};
  endfunction

  // Synchronous instruction memories: data the cycle after the request.
  always @(posedge clk) begin
    if (imem_re)   imem_data   <= mem_word(imem_addr);
    if (w_imem_re) w_imem_data <= mem_word(w_imem_addr);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic model_v();
    return (cyc - last_evt) >= 2;
  endfunction

  task automatic model_step(input logic s, input logic b, input logic [ADDR-1:0] ba);
    if (model_v() && !s) next_addr = next_addr + 8'd1;
    if (b) begin
      next_addr = ba;
      last_evt  = cyc;
    end
    cyc++;
  endtask

  typedef struct {
    logic            stall;
    logic            br;
    logic [ADDR-1:0] br_addr;
    logic            v;
    logic [ADDR-1:0] oa;
    logic            re;
    logic [ADDR-1:0] ia;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic s, input logic b, input logic [7:0] ba,
                              input logic ev, input logic [7:0] eoa,
                              input logic ere, input logic [7:0] eia);
    vec_t r;
    r.stall = s; r.br = b; r.br_addr = ba;
    r.v = ev; r.oa = eoa; r.re = ere; r.ia = eia;
    return r;
  endfunction

  initial begin
    // stall br  target  v  origaddr re imem_addr
    vecs[0]  = mk(0, 0, 8'h00, 0, 8'h00, 1, 8'h00);
    vecs[1]  = mk(0, 0, 8'h00, 0, 8'h00, 1, 8'h01);
    vecs[2]  = mk(0, 0, 8'h00, 1, 8'h00, 1, 8'h02);
    vecs[3]  = mk(0, 0, 8'h00, 1, 8'h01, 1, 8'h03);
    vecs[4]  = mk(1, 0, 8'h00, 1, 8'h02, 0, 8'h04);
    vecs[5]  = mk(1, 0, 8'h00, 1, 8'h02, 0, 8'h04);
    vecs[6]  = mk(1, 0, 8'h00, 1, 8'h02, 0, 8'h04);
    vecs[7]  = mk(0, 0, 8'h00, 1, 8'h02, 1, 8'h04);
    vecs[8]  = mk(0, 0, 8'h00, 1, 8'h03, 1, 8'h05);
    vecs[9]  = mk(0, 0, 8'h00, 1, 8'h04, 1, 8'h06);
    vecs[10] = mk(0, 1, 8'h40, 1, 8'h05, 1, 8'h40);
    vecs[11] = mk(0, 0, 8'h00, 0, 8'h00, 1, 8'h41);
    vecs[12] = mk(0, 0, 8'h00, 1, 8'h40, 1, 8'h42);
    vecs[13] = mk(0, 0, 8'h00, 1, 8'h41, 1, 8'h43);
    vecs[14] = mk(1, 0, 8'h00, 1, 8'h42, 0, 8'h44);
    vecs[15] = mk(1, 0, 8'h00, 1, 8'h42, 0, 8'h44);
    vecs[16] = mk(1, 1, 8'h80, 1, 8'h42, 1, 8'h80);
    vecs[17] = mk(1, 0, 8'h00, 0, 8'h00, 1, 8'h81);
    vecs[18] = mk(1, 0, 8'h00, 1, 8'h80, 0, 8'h82);
    vecs[19] = mk(0, 0, 8'h00, 1, 8'h80, 1, 8'h82);
    vecs[20] = mk(0, 0, 8'h00, 1, 8'h81, 1, 8'h83);
    vecs[21] = mk(0, 0, 8'h00, 1, 8'h82, 1, 8'h84);

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("reset_v", {31'h0, v}, 32'h0);
    check("reset_inst", inst, 32'h0);
    check("reset_origaddr", {24'h0, origaddr}, 32'h0);
    check("reset_re", {31'h0, imem_re}, 32'h1);
    check("reset_addr", {24'h0, imem_addr}, 32'h0);
    check("reset_wrap_addr", {24'h0, w_imem_addr}, 32'hFE);

    // Directed table: basic flow, stall, redirect, redirect under full stall.
    @(negedge clk);
    rst = 1'b1;
    cyc = 0; last_evt = 0; next_addr = 8'h00;
    for (int k = 0; k < 22; k++) begin
      if (k != 0) @(negedge clk);
      stall = vecs[k].stall; br = vecs[k].br; br_addr = vecs[k].br_addr;
      #1;
      check($sformatf("tbl%0d_v", k), {31'h0, v}, {31'h0, vecs[k].v});
      if (vecs[k].v) begin
        check($sformatf("tbl%0d_origaddr", k), {24'h0, origaddr}, {24'h0, vecs[k].oa});
        check($sformatf("tbl%0d_inst", k), inst, mem_word(vecs[k].oa));
      end
      check($sformatf("tbl%0d_re", k), {31'h0, imem_re}, {31'h0, vecs[k].re});
      if (vecs[k].re)
        check($sformatf("tbl%0d_imem_addr", k), {24'h0, imem_addr}, {24'h0, vecs[k].ia});
      // Wrap-around instance: FE, FF, 00, 01 ... from the third cycle.
      check($sformatf("wrap%0d_v", k), {31'h0, w_v}, {31'h0, k >= 2});
      if (k >= 2 && k < 8) begin
        check($sformatf("wrap%0d_origaddr", k), {24'h0, w_origaddr},
              {24'h0, 8'(8'hFE + 8'(k - 2))});
        check($sformatf("wrap%0d_inst", k), w_inst, mem_word(8'(8'hFE + 8'(k - 2))));
      end
      model_step(stall, br, br_addr);
    end

    // Randomized run against the stream model, with an async reset mid-way.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (i == 1000) begin
        stall = 1'b0; br = 1'b0; br_addr = '0;
        #1 rst = 1'b0;
        #1;
        check("areset_v", {31'h0, v}, 32'h0);
        check("areset_inst", inst, 32'h0);
        check("areset_origaddr", {24'h0, origaddr}, 32'h0);
        check("areset_re", {31'h0, imem_re}, 32'h1);
        check("areset_addr", {24'h0, imem_addr}, 32'h0);
        #1 rst = 1'b1;
        last_evt = cyc;
        next_addr = 8'h00;
      end else begin
        stall   = ($urandom_range(0, 3) == 0);
        br      = ($urandom_range(0, 15) == 0);
        br_addr = 8'($urandom_range(0, 255));
        #1;
      end
      check("rnd_v", {31'h0, v}, {31'h0, model_v()});
      if (model_v()) begin
        check("rnd_origaddr", {24'h0, origaddr}, {24'h0, next_addr});
        check("rnd_inst", inst, mem_word(next_addr));
      end
      if (!stall) check("rnd_re_unstalled", {31'h0, imem_re}, 32'h1);
      if (br) begin
        check("rnd_br_re", {31'h0, imem_re}, 32'h1);
        check("rnd_br_addr", {24'h0, imem_addr}, {24'h0, br_addr});
      end
      model_step(stall, br, br_addr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
